// File: rtl/fifo_pkg.sv
// Shared sizing helpers and flag bundle for the single-clock programmable FIFO.
// Imported by sync_fifo_ram and sync_fifo_prog.
package fifo_pkg;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int fifo_depth(input int awidth);
        return 1 << awidth;
    endfunction

    localparam int FIFO_DEF_AWIDTH = 4;
    localparam int FIFO_DEF_DEPTH  = fifo_depth(FIFO_DEF_AWIDTH);
    localparam int FIFO_DEF_LWIDTH = clog2(FIFO_DEF_DEPTH) + 1;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        full:         1'b0,
        almost_full:  1'b0,
        empty:        1'b1,
        almost_empty: 1'b1
    };

    // Thresholds compare as unsigned, so ae >= depth pins almost_empty high.
    function automatic fifo_flags_t calc_flags(
        input int unsigned lvl,
        input int unsigned af,
        input int unsigned ae,
        input int unsigned depth
    );
        fifo_flags_t f;
        f.full         = (lvl == depth);
        f.almost_full  = (lvl >= af);
        f.empty        = (lvl == 0);
        f.almost_empty = (lvl <= ae);
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DWIDTH storage for sync_fifo_prog: synchronous write, read port
// either combinational (show-ahead) or registered with a read enable.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4,
    parameter bit FWFT   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam int DEPTH = fifo_depth(AWIDTH);

    logic [DWIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM primitives; the
    // control logic never exposes an entry that was not written first.
    // NOTE: sequential state is assigned with <= so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (FWFT) begin : g_show_ahead
            assign rdata = mem[raddr];

            // Clocked read controls are only needed by the registered port.
            logic unused_rd_ctrl;
            assign unused_rd_ctrl = rst | re;
        end else begin : g_registered
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with binary fill level, programmable almost-full/empty
// thresholds, sticky overflow/underflow, synchronous flush and FWFT option.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = FIFO_DEF_AWIDTH,
    parameter bit FWFT   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              write_en,
    output logic              full,
    output logic              almost_full,
    input  logic              read_en,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    output logic              empty,
    output logic              almost_empty,
    output logic [AWIDTH:0]   level,
    input  logic [AWIDTH:0]   af_thresh,
    input  logic [AWIDTH:0]   ae_thresh,
    input  logic              flush,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int DEPTH  = fifo_depth(AWIDTH);
    localparam int LWIDTH = clog2(DEPTH) + 1;

    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] rptr;
    logic [LWIDTH-1:0] level_q;
    logic [LWIDTH-1:0] level_next;
    fifo_flags_t       flags_q;
    fifo_flags_t       flags_next;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_evt;
    logic              unf_evt;

    // Acceptance uses the registered flags; flush swallows both requests.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        level_next = level_q;
        if (!flush) begin
            wr_acc     = write_en && !flags_q.full;
            rd_acc     = read_en  && !flags_q.empty;
            ovf_evt    = write_en &&  flags_q.full;
            unf_evt    = read_en  &&  flags_q.empty;
            level_next = level_q + LWIDTH'(wr_acc) - LWIDTH'(rd_acc);
        end else begin
            level_next = '0;
        end
        flags_next = calc_flags(32'(level_next), 32'(af_thresh),
                                32'(ae_thresh), DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
            flags_q <= FLAGS_RESET;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_acc) wptr <= wptr + AWIDTH'(1);
                if (rd_acc) rptr <= rptr + AWIDTH'(1);
            end
            level_q <= level_next;
            flags_q <= flags_next;
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (unf_evt)      underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

    generate
        if (FWFT) begin : g_rvalid_show_ahead
            assign rvalid = !flags_q.empty;
        end else begin : g_rvalid_registered
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid <= 1'b0;
                end else begin
                    rvalid <= rd_acc;
                end
            end
        end
    endgenerate

    sync_fifo_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .FWFT   (FWFT)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rptr),
        .rdata (rdata)
    );

    assign level        = level_q;
    assign full         = flags_q.full;
    assign almost_full  = flags_q.almost_full;
    assign empty        = flags_q.empty;
    assign almost_empty = flags_q.almost_empty;

endmodule
